// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing for the CPU.
// In: clk, reset_n, mem_ready, instr_op/funct, alu_zero. Out: datapath controls.
module multicycle_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_ready,
  input  logic [5:0] instr_op,
  input  logic [5:0] instr_funct,
  input  logic       alu_zero,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ext_sel,
  output logic       alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [2:0] state_q, state_d;
  logic [5:0] op_q, funct_q;

  logic st_fetch, st_decode, st_exec;
  logic st_mem, st_wb, st_halt;

  assign st_fetch  = (state_q == S_FETCH);
  assign st_decode = (state_q == S_DECODE);
  assign st_exec   = (state_q == S_EXEC);
  assign st_mem    = (state_q == S_MEM);
  assign st_wb     = (state_q == S_WB);
  assign st_halt   = (state_q == S_HALT);

  logic is_r, i_jr, i_add, i_sub, i_slt;
  logic i_j, i_jal, i_bne, i_addi;
  logic i_xori, i_lw, i_sw;
  logic legal, alu_wb;

  assign is_r   = (op_q == OP_R);
  assign i_jr   = is_r && (funct_q == FN_JR);
  assign i_add  = is_r && (funct_q == FN_ADD);
  assign i_sub  = is_r && (funct_q == FN_SUB);
  assign i_slt  = is_r && (funct_q == FN_SLT);
  assign i_j    = (op_q == OP_J);
  assign i_jal  = (op_q == OP_JAL);
  assign i_bne  = (op_q == OP_BNE);
  assign i_addi = (op_q == OP_ADDI);
  assign i_xori = (op_q == OP_XORI);
  assign i_lw   = (op_q == OP_LW);
  assign i_sw   = (op_q == OP_SW);

  assign legal  = i_jr | i_add | i_sub | i_slt
                | i_j | i_jal | i_bne | i_addi
                | i_xori | i_lw | i_sw;
  assign alu_wb = i_add | i_sub | i_slt
                | i_addi | i_xori;

  // ALU/extender setting per instruction, shared by
  // EXEC and WB so the result is stable at writeback.
  logic [2:0] aop_i;
  logic       srcb_i, ext_i;

  always_comb begin
    aop_i = 3'b000;
    if (i_sub || i_bne) aop_i = 3'b001;
    else if (i_xori)    aop_i = 3'b010;
    else if (i_slt)     aop_i = 3'b011;
  end

  assign srcb_i = i_addi | i_xori | i_lw | i_sw;
  assign ext_i  = ~i_xori;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (i_j || i_jal) state_d = S_FETCH;
        else if (!legal)  state_d = S_HALT;
        else              state_d = S_EXEC;
      end
      S_EXEC: begin
        if (alu_wb)            state_d = S_WB;
        else if (i_lw || i_sw) state_d = S_MEM;
        else                   state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)
          state_d = i_lw ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (st_fetch && mem_ready) begin
        op_q    <= instr_op;
        funct_q <= instr_funct;
      end
    end
  end

  always_comb begin
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    ir_we        = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ext_sel      = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = 3'b000;
    reg_we       = 1'b0;
    reg_dst      = 2'b00;
    wb_sel       = 2'b00;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    unique case (1'b1)
      st_fetch: begin
        mem_re = 1'b1;
        ir_we  = mem_ready;
        pc_we  = mem_ready;
      end
      st_decode: begin
        if (i_j || i_jal) begin
          pc_we      = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
        if (i_jal) begin
          reg_we  = 1'b1;
          reg_dst = 2'b10;
          wb_sel  = 2'b10;
        end
      end
      st_exec: begin
        ext_sel   = ext_i;
        alu_op    = aop_i;
        alu_src_b = srcb_i;
        if (i_bne) begin
          pc_src     = 2'b01;
          pc_we      = ~alu_zero;
          instr_done = 1'b1;
        end
        if (i_jr) begin
          pc_src     = 2'b11;
          pc_we      = 1'b1;
          instr_done = 1'b1;
        end
      end
      st_mem: begin
        mem_addr_sel = 1'b1;
        alu_src_b    = 1'b1;
        ext_sel      = 1'b1;
        mem_re       = i_lw;
        mem_we       = i_sw;
        instr_done   = i_sw & mem_ready;
      end
      st_wb: begin
        ext_sel    = ext_i;
        alu_op     = aop_i;
        alu_src_b  = srcb_i;
        reg_we     = 1'b1;
        instr_done = 1'b1;
        reg_dst    = is_r ? 2'b01 : 2'b00;
        wb_sel     = i_lw ? 2'b01 : 2'b00;
      end
      st_halt: illegal = 1'b1;
      default: ;
    endcase
    // Reset must silence every enable immediately,
    // not just from the next clock edge.
    if (!reset_n) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state = state_q;

endmodule
